// File: rtl/regfile_wb_writer.sv
// Writeback queue feeding the 32x32 register file write port, drained one entry per cycle.
// Optional decode bypass from queued writes is built only when WB_BYPASS_EN is defined.
module regfile_wb_writer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_regwrite,
  input  logic                          in_memtoreg,
  input  logic [4:0]                    in_rd,
  input  logic [DATA_W-1:0]             in_alu_result,
  input  logic [DATA_W-1:0]             in_mem_data,
  input  logic                          drain_en,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  input  logic [4:0]                    byp_rs,
  input  logic [4:0]                    byp_rt,
  output logic                          byp_rs_hit,
  output logic                          byp_rt_hit,
  output logic [DATA_W-1:0]             byp_rs_data,
  output logic [DATA_W-1:0]             byp_rt_data,
  output logic [$clog2(DEPTH):0]        pending,
  output logic                          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 5;

  typedef struct packed {
    logic [RW-1:0]     rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head_c;
  entry_t          new_entry_c;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_c;
  logic            push_c;

  // Handshake: a full queue still accepts when the head retires this cycle.
  assign pop_c    = (count_q != '0) && drain_en;
  assign in_ready = (count_q < CW'(DEPTH)) || pop_c;
  assign push_c   = in_valid && in_ready && in_regwrite && (in_rd != '0);

  assign new_entry_c.rd   = in_rd;
  assign new_entry_c.data = in_memtoreg ? in_mem_data : in_alu_result;

  // Write port driven straight from the head so it is stable for the falling-edge write.
  assign head_c   = mem_q[rptr_q];
  assign rf_we    = pop_c;
  assign rf_waddr = (count_q != '0) ? head_c.rd   : '0;
  assign rf_wdata = (count_q != '0) ? head_c.data : '0;

  assign pending = count_q;
  assign empty   = (count_q == '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_c) wptr_d = wptr_q + AW'(1);
    if (pop_c)  rptr_d = rptr_q + AW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wptr_q] <= new_entry_c;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the youngest matching entry overrides older ones.
  always_comb begin
    logic [AW-1:0] idx;
    byp_rs_hit  = 1'b0;
    byp_rt_hit  = 1'b0;
    byp_rs_data = '0;
    byp_rt_data = '0;
    idx         = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = rptr_q + AW'(k);
      if (CW'(k) < count_q) begin
        if ((byp_rs != '0) && (mem_q[idx].rd == byp_rs)) begin
          byp_rs_hit  = 1'b1;
          byp_rs_data = mem_q[idx].data;
        end
        if ((byp_rt != '0) && (mem_q[idx].rd == byp_rt)) begin
          byp_rt_hit  = 1'b1;
          byp_rt_data = mem_q[idx].data;
        end
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp  = ^{byp_rs, byp_rt};
  assign byp_rs_hit  = 1'b0;
  assign byp_rt_hit  = 1'b0;
  assign byp_rs_data = '0;
  assign byp_rt_data = '0;
`endif

endmodule

// File: doc/regfile_wb_writer.md
Name: regfile_wb_writer

Overview:
Writeback-side driver for the 32x32 register file write port. Accepts retiring results from the MEM/WB boundary over a valid/ready handshake and selects ALU or load data. Queues accepted writes in a small circular buffer and drains one entry per cycle onto the register file write port (rf_we / rf_waddr / rf_wdata). Optionally supplies decode-stage bypass data for registers whose writes are still queued.

Parameters:
DEPTH, 4, number of queued write entries; power of two, minimum 2.
DATA_W, 32, register data width.

Ports:
clk  input  1  core clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  writeback request present.
in_ready  output  1  request accepted this cycle when high together with in_valid.
in_regwrite  input  1  request actually writes a register.
in_memtoreg  input  1  1 = write in_mem_data, 0 = write in_alu_result.
in_rd  input  5  destination register number.
in_alu_result  input  DATA_W  ALU result.
in_mem_data  input  DATA_W  load data.
drain_en  input  1  permits draining the buffer head this cycle.
rf_we  output  1  register file write enable.
rf_waddr  output  5  register file write address.
rf_wdata  output  DATA_W  register file write data.
byp_rs  input  5  decode read port 1 register number.
byp_rt  input  5  decode read port 2 register number.
byp_rs_hit  output  1  pending write to byp_rs exists.
byp_rt_hit  output  1  pending write to byp_rt exists.
byp_rs_data  output  DATA_W  youngest pending data for byp_rs.
byp_rt_data  output  DATA_W  youngest pending data for byp_rt.
pending  output  log2(DEPTH)+1  current entry count.
empty  output  1  pending == 0.

Behaviour:
- Reset (reset low, asynchronous): count, write and read pointers = 0; rf_we=0, rf_waddr=0, rf_wdata=0; all bypass hits 0; empty=1. Asserting reset mid-operation discards queued entries; those writes are never issued.
- pop = (count != 0) && drain_en. push = in_valid && in_ready && in_regwrite && (in_rd != 0).
- in_ready = (count < DEPTH) || pop. Combinational; when full, it is high only in a cycle that pops.
- Requests with in_regwrite=0 or in_rd=0 are accepted (handshake completes) but do not create an entry; no write to r0 is ever issued.
- Enqueued data is selected at enqueue: in_memtoreg ? in_mem_data : in_alu_result. The entry stores {rd, data}.
- Write port is combinational from the head entry: rf_we = pop, rf_waddr/rf_wdata = head rd/data when count != 0, else 0. Values are stable across the whole cycle, so the register file's falling-edge write captures them. The head pops at the following posedge.
- Latency: an accepted request into an empty buffer appears on the write port in the next cycle and is written at that cycle's falling edge (when drain_en=1).
- Simultaneous push and pop: count unchanged; both pointers advance. This is legal when full.
- Pointers wrap modulo DEPTH. Ordering is strict FIFO, so two writes to the same rd retire in program order.
- drain_en=0: rf_we=0, buffer holds, and accepts continue until full.
- pending/empty reflect the registered count.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: for each bypass port, all valid entries are scanned and the youngest entry with matching rd (rd != 0) wins. hit=1 and data is that entry's value. The head entry being drained this cycle still counts as a hit. Entries being accepted this cycle do not hit until the next cycle.
- Not defined: byp_rs_hit = byp_rt_hit = 0 and byp_rs_data = byp_rt_data = 0; no comparators are synthesized. Ports remain present.

Test Plan:
- Reset then single write: in_valid=1, rd=5, memtoreg=0, alu=0x1234, drain_en=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234; following cycle empty=1.
- Load select and r0 filter: rd=8, memtoreg=1, mem=0xDEADBEEF -> writes 0xDEADBEEF to r8. Then rd=0, regwrite=1 -> in_ready=1, no rf_we, pending stays 0.
- Fill and backpressure: drain_en=0, push rd=1..4 -> pending=4, in_ready=0. Set drain_en=1 with a 5th request rd=9 -> accepted the same cycle. Writes retire in order 1,2,3,4,9 on consecutive cycles.
- Wrap-around: push and pop 10 consecutive writes rd=1..10 with data=rd*0x11 -> each is written exactly once, in order, with pending never above 1.
- Bypass (WB_BYPASS_EN): drain_en=0, push rd=7 data=0xA, then rd=7 data=0xB; byp_rs=7, byp_rt=3 -> rs_hit=1, rs_data=0xB, rt_hit=0. Without the macro -> both hits 0.
- Reset mid-operation: 3 entries queued, pulse reset low for half a cycle -> rf_we=0 and pending=0 immediately; no further writes are issued.
